// File: rtl/sig_pkg.sv
// Shared types and default widths for the microphone conditioning path.
// No logic; constants and the output-stage state encoding only.
// Imported by the decimator top and its accumulator.
package sig_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int LOG2_DECIM_DEF = 2;

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } out_state_t;

endpackage

// File: rtl/boxcar_accum.sv
// Boxcar accumulator: sums 2^LOG2_DECIM accepted samples and emits a rounded mean.
// Latency: done/result are combinational in the cycle the last sample is accepted.
// Backpressure: none; every qualified sample is absorbed.
module boxcar_accum
    import sig_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_sample,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int AW = DATA_WIDTH + LOG2_DECIM;
    localparam logic [AW-1:0] HALF = AW'(1) << (LOG2_DECIM - 1);

    logic [AW-1:0]         acc;
    logic [LOG2_DECIM-1:0] cnt;
    logic                  accept;
    logic                  last;
    logic [AW-1:0]         sum;
    logic [AW-1:0]         rounded;

    assign accept  = en && in_valid && !flush;
    assign last    = (cnt == '1);
    assign sum     = acc + AW'(in_sample);
    // Worst case 2^L*(2^D-1) + 2^(L-1) still fits in AW bits, so no saturation.
    assign rounded = sum + HALF;
    assign done    = accept && last;
    assign result  = rounded[AW-1:LOG2_DECIM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + LOG2_DECIM'(1);
            end
        end
    end

endmodule

// File: rtl/mic_decimator.sv
// Mic decimator: averages groups of 2^LOG2_DECIM samples, one result per group.
// Latency: out_valid rises one clock after the last sample of a group is accepted.
// Backpressure: input never stalls; a stalled result is overwritten and overrun latches.
module mic_decimator
    import sig_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  overrun
);

    out_state_t            state;
    logic                  acc_done;
    logic [DATA_WIDTH-1:0] acc_result;

    boxcar_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_DECIM (LOG2_DECIM)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .done      (acc_done),
        .result    (acc_result)
    );

    assign out_valid = (state == PENDING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            out_sample <= '0;
            overrun    <= 1'b0;
        end else begin
            // Latest result wins; a same-cycle consume makes the reload loss-free.
            if (acc_done) begin
                out_sample <= acc_result;
                state      <= PENDING;
            end else if (out_valid && out_ready) begin
                state <= EMPTY;
            end

            if (flush) begin
                overrun <= 1'b0;
            end else if (acc_done && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mic_decimator.sv
// Directed bench for mic_decimator with LOG2_DECIM = 2 and hand-computed expectations.
module tb_mic_decimator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_sample = 8'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_sample;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    mic_decimator #(
        .DATA_WIDTH (8),
        .LOG2_DECIM (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then land 1 time unit after the sampling edge.
    task automatic step(input logic e, input logic v, input logic [7:0] s,
                        input logic r, input logic f);
        en        = e;
        in_valid  = v;
        in_sample = s;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic r);
        step(1'b1, 1'b1, a, r, 1'b0);
        step(1'b1, 1'b1, b, r, 1'b0);
        step(1'b1, 1'b1, c, r, 1'b0);
        step(1'b1, 1'b1, d, r, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_sample", out_sample, 0);
        check("reset_overrun", overrun, 0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        rst = 1'b0;

        // Basic average
        step(1'b1, 1'b1, 8'd10, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd20, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd30, 1'b1, 1'b0);
        check("basic_not_yet", out_valid, 0);
        step(1'b1, 1'b1, 8'd40, 1'b1, 1'b0);
        check("basic_valid", out_valid, 1);
        check("basic_sample", out_sample, 25);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        check("basic_pulse_end", out_valid, 0);

        // Rounding
        feed4(8'd1, 8'd1, 8'd1, 8'd2, 1'b1);
        check("round_1112", out_sample, 1);
        feed4(8'd1, 8'd2, 8'd2, 8'd2, 1'b1);
        check("round_1222", out_sample, 2);
        feed4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        check("round_max", out_sample, 255);
        check("round_max_ovr", overrun, 0);
        feed4(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        check("round_zero_valid", out_valid, 1);
        check("round_zero", out_sample, 0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

        // Overrun: two groups with consumer stalled
        feed4(8'd25, 8'd25, 8'd25, 8'd25, 1'b0);
        check("ovr_first_sample", out_sample, 25);
        check("ovr_first_flag", overrun, 0);
        feed4(8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
        check("ovr_sample", out_sample, 50);
        check("ovr_flag", overrun, 1);
        check("ovr_valid_held", out_valid, 1);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        check("ovr_drained", out_valid, 0);
        check("ovr_sticky", overrun, 1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        check("ovr_flush_clear", overrun, 0);

        // Simultaneous consume and complete
        feed4(8'd8, 8'd8, 8'd8, 8'd8, 1'b0);
        check("sim_first", out_sample, 8);
        step(1'b1, 1'b1, 8'd16, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd16, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd16, 1'b0, 1'b0);
        check("sim_stable", out_sample, 8);
        step(1'b1, 1'b1, 8'd16, 1'b1, 1'b0);
        check("sim_valid", out_valid, 1);
        check("sim_sample", out_sample, 16);
        check("sim_no_ovr", overrun, 0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        check("sim_drained", out_valid, 0);

        // en / in_valid gaps: accepted samples are 4, 8, 12, 16
        step(1'b0, 1'b1, 8'd200, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd4,   1'b1, 1'b0);
        step(1'b1, 1'b0, 8'd100, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd8,   1'b1, 1'b0);
        step(1'b0, 1'b1, 8'd250, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd12,  1'b1, 1'b0);
        check("gap_not_yet", out_valid, 0);
        step(1'b1, 1'b1, 8'd16,  1'b0, 1'b0);
        check("gap_valid", out_valid, 1);
        check("gap_sample", out_sample, 10);
        step(1'b0, 1'b1, 8'd77, 1'b1, 1'b0);
        check("gap_en_low_handshake", out_valid, 0);

        // Asynchronous reset mid-group
        feed4(8'd60, 8'd60, 8'd60, 8'd60, 1'b0);
        check("rst_pre_sample", out_sample, 60);
        step(1'b1, 1'b1, 8'd100, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd100, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_sample", out_sample, 0);
        #1 rst = 1'b0;
        feed4(8'd20, 8'd20, 8'd20, 8'd24, 1'b1);
        check("rst_new_valid", out_valid, 1);
        check("rst_new_sample", out_sample, 21);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

        // Flush mid-group with overrun set
        feed4(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        feed4(8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
        check("flush_pre_ovr", overrun, 1);
        step(1'b1, 1'b1, 8'd200, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd200, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd200, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd200, 1'b0, 1'b1);
        check("flush_ovr_clear", overrun, 0);
        check("flush_pending_kept", out_valid, 1);
        check("flush_pending_sample", out_sample, 9);
        feed4(8'd4, 8'd4, 8'd4, 8'd4, 1'b1);
        check("flush_new_valid", out_valid, 1);
        check("flush_new_sample", out_sample, 4);
        check("flush_new_ovr", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_decimator.md
# mic_decimator

Upstream conditioning stage for the signal-delay path. Accepts raw unsigned microphone samples on a valid strobe, averages each non-overlapping group of 2^LOG2_DECIM samples with round-half-up, and presents one averaged sample per group on a valid/ready handshake. The accepted output drives the delay line's `mic_signal` input, with its write/read strobes tied to `out_valid && out_ready`. An overrun flag reports results lost because the consumer stalled.

## Interface

Parameters:
- DATA_WIDTH, 8, sample width in and out (unsigned, offset-binary).
- LOG2_DECIM, 2, log2 of the decimation factor; legal range 1..6.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  accept enable; when 0, `in_valid` is ignored and partial accumulation is held.
- flush  in  1  synchronous clear of the accumulator, the sample count and `overrun`.
- in_valid  in  1  `in_sample` is valid this cycle.
- in_sample  in  DATA_WIDTH  raw microphone sample.
- out_ready  in  1  consumer accepts `out_sample` this cycle.
- out_valid  out  1  `out_sample` holds an unconsumed result.
- out_sample  out  DATA_WIDTH  averaged sample.
- overrun  out  1  sticky; set when a pending result is overwritten.

## Operation

- **Accept condition:** a sample is accepted when `en && in_valid && !flush`.
- **Accumulator:** `acc` is DATA_WIDTH+LOG2_DECIM bits; the sample count `cnt` is LOG2_DECIM bits.
- **Normal accept:** `acc += in_sample`, `cnt++`.
- **Group completion:** on an accept with `cnt == 2^LOG2_DECIM-1`:
  - the result is `(acc + in_sample + 2^(LOG2_DECIM-1)) >> LOG2_DECIM`;
  - `acc` and `cnt` return to 0.
- **Width rule:** the rounded sum never exceeds 2^(DATA_WIDTH+LOG2_DECIM)-1, so no saturation logic is needed. All-max input yields exactly 2^DATA_WIDTH-1.
- **Output FSM, EMPTY:** `out_valid` = 0. On completion, load `out_sample` and go to PENDING.
- **Output FSM, PENDING:** `out_valid` = 1.
  - `out_ready` and no completion: go to EMPTY.
  - Completion with `out_ready`: old result is consumed, new result loads, stay PENDING, no overrun.
  - Completion without `out_ready`: new result overwrites (latest wins), `overrun` is set, stay PENDING.
- **flush:**
  - Clears `acc`, `cnt` and `overrun`. The in-flight sample that cycle is discarded.
  - Does not affect a PENDING result, which is still offered and consumed normally.
- **en low:** the output handshake continues unaffected.

## Timing

- **Reset values:** `out_valid` = 0, `out_sample` = 0, `overrun` = 0, `acc` = 0, `cnt` = 0, FSM = EMPTY. Reset applies immediately on `rst` assertion, independent of `clk`.
- **Reset mid-group:** the partial sum is discarded; the first accepted sample after release starts a new group.
- **Latency:** `out_valid` rises on the clock edge after the cycle the last sample of a group is accepted (1 cycle).
- **Transfer:** a transfer occurs on any cycle with `out_valid && out_ready`. `out_valid` falls on the following edge unless a new result completes that same cycle.
- **Throughput:** one sample accepted per cycle sustained, one result per 2^LOG2_DECIM accepts. There is no input backpressure; input is never stalled.
- **Stability:** `out_sample` is stable while PENDING, except on an overwrite.
- **Overrun clearing:** `overrun` clears only on `rst` or `flush`. If `flush` and an overwrite occur in the same cycle, `flush` wins (`overrun` = 0).

## Structure

- **Shared package** (`sig_pkg`):
  - the `out_state_t` enum (EMPTY, PENDING);
  - the default width constants DATA_WIDTH_DEF = 8 and LOG2_DECIM_DEF = 2.
- **Sub-module** `boxcar_accum`: owns `acc`, `cnt`, the rounding adder and the completion strobe. Its outputs are `done` and `result`.
- **Top:** instantiates `boxcar_accum` and holds the output FSM, the `out_sample` register and the `overrun` flag.

## Test plan

All scenarios use LOG2_DECIM = 2.

1. **Basic average:** feed 10, 20, 30, 40 with `out_ready` = 1 → `out_valid` pulses one cycle after the 4th accept with `out_sample` = 25.
2. **Rounding:**
   - 1, 1, 1, 2 → 1;
   - 1, 2, 2, 2 → 2;
   - 255 ×4 → 255;
   - 0 ×4 → 0.
3. **Overrun:** hold `out_ready` = 0 and feed 8 samples (groups summing to 100 and 200) → `out_sample` = 50, `overrun` = 1, `out_valid` held. Raising `out_ready` for one cycle gives one transfer of 50, then `out_valid` = 0.
4. **Simultaneous consume and complete:** while PENDING, assert `out_ready` on the cycle the next group completes → `out_valid` stays 1, the new value is loaded, `overrun` stays 0.
5. **en and in_valid gaps:** interleave `en` = 0 cycles and `in_valid` = 0 gaps within a group → the result equals the average of accepted samples only.
6. **Reset and flush mid-group:**
   - Assert `rst` asynchronously after 2 samples → outputs are 0 immediately; the next 4 samples give their own average.
   - A `flush` after 3 samples discards them and clears `overrun`.
